// File: rtl/d_ff_pkg.sv
// Shared constants for the d_ff_rp register family.
// RST_VAL is the per-bit value forced by rst.
// PRESET_ALL_ONES is the source for the default preset value. A user of the
// package takes the low WIDTH bits of it, for any WIDTH up to 64.
package d_ff_pkg;

  localparam logic        RST_VAL         = 1'b0;
  localparam logic [63:0] PRESET_ALL_ONES = '1;

endpackage : d_ff_pkg

// File: rtl/d_ff_bit.sv
// Single-bit D flop with asynchronous active-high reset and preset.
// Reset has priority over preset. A clock edge is ignored while either is high.
module d_ff_bit
  import d_ff_pkg::*;
#(
  parameter logic PRESET_BIT = 1'b1
) (
  output logic q,
  input  logic d,
  input  logic clk,
  input  logic rst,
  input  logic prs
);

  // Preset is qualified by ~rst. The flop then sees a rising preset edge when
  // rst falls while prs is still high, and reloads the preset value without
  // waiting for clk. It also gives rst priority in the logic itself, so the
  // priority does not depend only on the order of the branches below.
  logic prs_set;
  assign prs_set = prs & ~rst;

  // Flop with async clear/set; the data path is taken only on a clean clk edge.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst or posedge prs_set) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (prs_set) begin
      q <= PRESET_BIT;
    end else begin
      q <= d;
    end
  end

endmodule : d_ff_bit

// File: rtl/d_ff_rp.sv
// WIDTH-bit register with asynchronous active-high reset (to 0) and preset
// (to PRESET_VAL). Reset wins over preset.
// Optional feature: define D_FF_RP_QN_EN to add the complement output q_n.
// q_n is placed last in the port list.
// WIDTH legal range is 1..64.
module d_ff_rp
  import d_ff_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter logic [WIDTH-1:0] PRESET_VAL = PRESET_ALL_ONES[WIDTH-1:0]
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst,
  input  logic             prs
`ifdef D_FF_RP_QN_EN
  ,
  output logic [WIDTH-1:0] q_n
`endif
);

  // One independent bit cell per data bit; each cell gets its own preset bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_bit #(
      .PRESET_BIT(PRESET_VAL[i])
    ) u_bit (
      .q  (q[i]),
      .d  (d[i]),
      .clk(clk),
      .rst(rst),
      .prs(prs)
    );
  end

`ifdef D_FF_RP_QN_EN
  // The complement is purely combinational, so it also tracks q during rst and prs.
  assign q_n = ~q;
`endif

endmodule : d_ff_rp

// File: tb/tb_d_ff_rp.sv
// Self-checking bench for d_ff_rp.
// u_dut1 is a 1-bit instance with default parameters and covers the timed
// corner sequences.
// u_dut8 is an 8-bit instance with preset value A5. It runs a vector table
// and then random traffic against a reference model.
module tb_d_ff_rp;

  localparam logic [7:0] P8 = 8'hA5;

  logic       clk = 1'b0;
  logic       d1, rst1, prs1, q1;
  logic [7:0] d8, q8;
  logic       rst8, prs8;
`ifdef D_FF_RP_QN_EN
  logic       q1_n;
  logic [7:0] q8_n;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_ff_rp u_dut1 (
    .q  (q1),
    .d  (d1),
    .clk(clk),
    .rst(rst1),
    .prs(prs1)
`ifdef D_FF_RP_QN_EN
    ,
    .q_n(q1_n)
`endif
  );

  d_ff_rp #(
    .WIDTH     (8),
    .PRESET_VAL(P8)
  ) u_dut8 (
    .q  (q8),
    .d  (d8),
    .clk(clk),
    .rst(rst8),
    .prs(prs8)
`ifdef D_FF_RP_QN_EN
    ,
    .q_n(q8_n)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the 8-bit instance and, when present, its complement output.
  task automatic check8(input string name, input logic [7:0] exp);
    check(name, 64'(q8), 64'(exp));
`ifdef D_FF_RP_QN_EN
    check({name, "_qn"}, 64'(q8_n), 64'(~exp));
`endif
  endtask

  typedef struct packed {
    logic       rst;
    logic       prs;
    logic [7:0] d;
    logic       edge_en;
    logic [7:0] q;
  } vec_t;

  vec_t vecs [12];

  logic [7:0] model;
  logic       r_rst, r_prs;
  logic [7:0] r_d;
  int         sel;

  initial begin
    vecs[0]  = '{rst:1'b0, prs:1'b1, d:8'h3C, edge_en:1'b0, q:8'hA5};
    vecs[1]  = '{rst:1'b0, prs:1'b0, d:8'h3C, edge_en:1'b0, q:8'hA5};
    vecs[2]  = '{rst:1'b0, prs:1'b0, d:8'h3C, edge_en:1'b1, q:8'h3C};
    vecs[3]  = '{rst:1'b0, prs:1'b0, d:8'hFF, edge_en:1'b1, q:8'hFF};
    vecs[4]  = '{rst:1'b1, prs:1'b0, d:8'h55, edge_en:1'b0, q:8'h00};
    vecs[5]  = '{rst:1'b1, prs:1'b0, d:8'h55, edge_en:1'b1, q:8'h00};
    vecs[6]  = '{rst:1'b1, prs:1'b1, d:8'h55, edge_en:1'b0, q:8'h00};
    vecs[7]  = '{rst:1'b0, prs:1'b1, d:8'h55, edge_en:1'b0, q:8'hA5};
    vecs[8]  = '{rst:1'b0, prs:1'b1, d:8'h00, edge_en:1'b1, q:8'hA5};
    vecs[9]  = '{rst:1'b0, prs:1'b0, d:8'h00, edge_en:1'b0, q:8'hA5};
    vecs[10] = '{rst:1'b0, prs:1'b0, d:8'h00, edge_en:1'b1, q:8'h00};
    vecs[11] = '{rst:1'b0, prs:1'b0, d:8'h81, edge_en:1'b1, q:8'h81};

    // Reset state
    d1 = 1'b1; rst1 = 1'b1; prs1 = 1'b0;
    d8 = 8'hFF; rst8 = 1'b1; prs8 = 1'b0;
    #2;
    check("reset_q1", 64'(q1), 64'd0);
    check8("reset_q8", 8'h00);
    @(posedge clk); #1;
    check("reset_hold_q1", 64'(q1), 64'd0);
    check8("reset_hold_q8", 8'h00);
`ifdef D_FF_RP_QN_EN
    check("reset_q1_n", 64'(q1_n), 64'd1);
`endif
    @(negedge clk); #1;
    rst1 = 1'b0; rst8 = 1'b0; d1 = 1'b0;

    // Preset pulse, then reset pulse, both between clock edges
    @(posedge clk); #1;
    prs1 = 1'b1; #1;
    check("prs_pulse_q1", 64'(q1), 64'd1);
    #1; prs1 = 1'b0; rst1 = 1'b1; #1;
    check("rst_pulse_q1", 64'(q1), 64'd0);
    rst1 = 1'b0;

    // Capture, with d changing mid-cycle
    @(negedge clk); #1; d1 = 1'b1;
    @(posedge clk); #1;
    check("capture_q1", 64'(q1), 64'd1);
    @(negedge clk); #1; d1 = 1'b0; #1;
    check("capture_hold_q1", 64'(q1), 64'd1);
    @(posedge clk); #1;
    check("capture_next_q1", 64'(q1), 64'd0);

    // Both forces asserted, then rst released while prs stays high
    @(negedge clk); #1;
    rst1 = 1'b1; prs1 = 1'b1; #1;
    check("prio_both_q1", 64'(q1), 64'd0);
    rst1 = 1'b0; #1;
    check("prio_rst_fall_q1", 64'(q1), 64'd1);
    prs1 = 1'b0; d1 = 1'b0; #1;
    check("prio_release_hold_q1", 64'(q1), 64'd1);
    @(posedge clk); #1;
    check("prio_resume_q1", 64'(q1), 64'd0);

    // Preset held across a clock edge
    @(negedge clk); #1;
    d1 = 1'b0; prs1 = 1'b1;
    @(posedge clk); #1;
    check("edge_block_q1", 64'(q1), 64'd1);
    @(negedge clk); #1; prs1 = 1'b0; #1;
    check("edge_block_hold_q1", 64'(q1), 64'd1);
    @(posedge clk); #1;
    check("edge_block_resume_q1", 64'(q1), 64'd0);

    // d changes just before a falling edge
    @(posedge clk); #4; d1 = 1'b1;
    @(negedge clk); #1;
    check("fall_edge_q1", 64'(q1), 64'd0);
    @(posedge clk); #1;
    check("fall_edge_next_rise_q1", 64'(q1), 64'd1);

    // Vector table on the 8-bit instance
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      rst8 = vecs[i].rst; prs8 = vecs[i].prs; d8 = vecs[i].d;
      if (vecs[i].edge_en) begin
        @(posedge clk); #1;
      end else begin
        #1;
      end
      check8($sformatf("vec%0d", i), vecs[i].q);
    end

    // Random traffic against the reference model.
    // The model holds the last value loaded into the register. A force applied
    // mid-cycle loads 0 or the preset value at once. A clock edge loads d only
    // while neither force is high.
    model = 8'h81;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); #1;
      sel   = int'($urandom_range(0, 9));
      r_rst = (sel < 2);
      r_prs = (sel == 1) || (sel == 2) || (sel == 3);
      r_d   = 8'($urandom);
      rst8 = r_rst; prs8 = r_prs; d8 = r_d;
      if (r_rst) model = 8'h00;
      else if (r_prs) model = P8;
      #1;
      check8("rand_mid", model);
      @(posedge clk);
      if (!r_rst && !r_prs) model = r_d;
      #1;
      check8("rand_edge", model);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_d_ff_rp
